text_line_renderer: RTL and testbench

Upstream feeder for the `characters` glyph ROM. It holds a small text buffer of ASCII codes and maps the VGA timing generator's pixel coordinates onto a scaled character box. It drives the ROM's `select`/`coor_x`/`coor_y` inputs and turns the returned `pixel` into a registered RGB pixel, with hsync/vsync delayed to match. It sits between the VGA timing generator and the VGA output pins.

---
 rtl/text_line_renderer.sv | 132 +++++++++++++
 tb/tb_text_line_renderer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_line_renderer.sv
// text_line_renderer: text buffer feeding the glyph ROM, with a 2-stage RGB/sync pipeline for VGA
module text_line_renderer #(
  parameter int          NUM_CHARS  = 16,
  parameter int          SCALE_LOG2 = 2,
  parameter int          ORIGIN_X   = 64,
  parameter int          ORIGIN_Y   = 64,
  parameter logic [11:0] FG_COLOR   = 12'hFFF,
  parameter logic [11:0] BG_COLOR   = 12'h000,
  parameter int          ADDR_W     = $clog2(NUM_CHARS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       hc,
  input  logic [10:0]       vc,
  input  logic              video_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_char,
  input  logic              clr,
  output logic [7:0]        char_select,
  output logic [2:0]        char_x,
  output logic [2:0]        char_y,
  input  logic              char_pixel,
  output logic [11:0]       rgb_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              video_out
);
  localparam int CELL_W = 8 << SCALE_LOG2;
  localparam logic [10:0] X_LO = 11'(ORIGIN_X);
  localparam logic [10:0] X_HI = 11'(ORIGIN_X + NUM_CHARS * CELL_W);
  localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + CELL_W);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_CHARS - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, col;
  logic wr_ready_q, wr_ready_d, in_range, in_box;
  logic [7:0] text_q [NUM_CHARS];
  logic [10:0] rx, ry;
  logic [2:0] cx, cy;
  logic [7:0] sel_q, sel_d;
  logic [2:0] x_q, x_d, y_q, y_d;
  logic lit_q, lit_d, vid1_q, hs1_q, vs1_q, vid2_q, hs2_q, vs2_q;
  logic [11:0] rgb_q, rgb_d;

  assign in_range = int'(wr_addr) < NUM_CHARS;
  assign rx = hc - X_LO;
  assign ry = vc - Y_LO;
  assign in_box = hc >= X_LO && hc < X_HI && vc >= Y_LO && vc < Y_HI;
  assign col = ADDR_W'(rx >> (3 + SCALE_LOG2));
  assign cx = 3'(rx >> SCALE_LOG2);
  assign cy = 3'(ry >> SCALE_LOG2);

  // buffer control: walk ptr through every entry while clearing, otherwise wait for clr
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    if (state_q == CLEAR) begin
      state_d = ptr_q == LAST ? IDLE : CLEAR;
      ptr_d = ptr_q == LAST ? '0 : ptr_q + ADDR_W'(1);
    end else if (clr) begin
      state_d = CLEAR;
      ptr_d = '0;
    end
    wr_ready_d = state_d == IDLE;
  end

  // stage-1 ROM addressing and stage-2 colour; columns 5-7 of a cell never light
  always_comb begin
    sel_d = in_box ? text_q[col] : 8'd32;
    x_d = in_box ? cx : 3'd0;
    y_d = in_box ? cy : 3'd0;
    lit_d = in_box && cx < 3'd5;
    rgb_d = !vid1_q ? 12'h000 : (lit_q && char_pixel ? FG_COLOR : BG_COLOR);
  end

  // control state and both pipeline stages
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q <= '0;
      wr_ready_q <= 1'b0;
      sel_q <= '0;
      x_q <= '0;
      y_q <= '0;
      lit_q <= 1'b0;
      vid1_q <= 1'b0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      rgb_q <= '0;
      vid2_q <= 1'b0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      wr_ready_q <= wr_ready_d;
      sel_q <= sel_d;
      x_q <= x_d;
      y_q <= y_d;
      lit_q <= lit_d;
      vid1_q <= video_in;
      hs1_q <= hsync_in;
      vs1_q <= vsync_in;
      rgb_q <= rgb_d;
      vid2_q <= vid1_q;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
    end
  end

  // text buffer: clear writes win; out-of-range user writes are accepted but dropped
  always_ff @(posedge clk) begin
    if (!rst && state_q == CLEAR) text_q[ptr_q] <= 8'd32;
    else if (!rst && wr_valid && wr_ready_q && in_range) text_q[wr_addr] <= wr_char;
  end

  assign wr_ready = wr_ready_q;
  assign char_select = sel_q;
  assign char_x = x_q;
  assign char_y = y_q;
  assign rgb_out = rgb_q;
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;
  assign video_out = vid2_q;
endmodule

// File: tb/tb_text_line_renderer.sv
// tb_text_line_renderer: directed stimulus checked against a screen-level model of the text line
module tb_text_line_renderer;
  localparam int N = 16, S = 2, OX = 64, OY = 64;
  localparam int DOT = 1 << S;
  localparam int CW = 8 * DOT;

  logic clk = 1'b0, rst = 1'b1;
  logic [10:0] hc = '0, vc = '0;
  logic video_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0, wr_valid = 1'b0, clr = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_char = '0;
  logic wr_ready, char_pixel, hsync_out, vsync_out, video_out;
  logic [7:0] char_select;
  logic [2:0] char_x, char_y;
  logic [11:0] rgb_out;

  int n_chk = 0, n_fail = 0, lit_cnt = 0;

  logic [7:0] mbuf [N];
  int busy = 0;
  logic armed = 1'b0;
  logic [7:0] e1_sel = '0;
  logic [2:0] e1_x = '0, e1_y = '0;
  logic [11:0] e1_rgb = '0, e2_rgb = '0;
  logic e1_hs = 1'b0, e1_vs = 1'b0, e1_vid = 1'b0, e2_hs = 1'b0, e2_vs = 1'b0, e2_vid = 1'b0, e_ready = 1'b0;
  logic [10:0] hc_d1 = '0, hc_d2 = '0;
  logic [7:0] sel_seen [2048];
  logic [11:0] rgb_seen [2048];

  text_line_renderer dut (
    .clk(clk), .rst(rst), .hc(hc), .vc(vc), .video_in(video_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_char(wr_char), .clr(clr), .char_select(char_select),
    .char_x(char_x), .char_y(char_y), .char_pixel(char_pixel), .rgb_out(rgb_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .video_out(video_out)
  );

  always #5 clk = ~clk;

  // bench glyph ROM: deliberately drives 1 in spacing columns 5-7
  function automatic logic rom(input logic [7:0] s, input int x, input int y);
    if (x >= 5) return 1'b1;
    case (s)
      8'd97: return y == 2 && x >= 1 && x <= 3;
      8'd122, 8'd56, 8'd65: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign char_pixel = rom(char_select, int'(char_x), int'(char_y));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: what the screen and the handshake must look like, from geometry and buffer contents
  initial forever begin
    int h, v, rx, cl, dx, dy;
    logic lit;
    @(posedge clk);
    armed = 1'b1;
    hc_d2 = hc_d1;
    hc_d1 = hc;
    e2_rgb = e1_rgb; e2_hs = e1_hs; e2_vs = e1_vs; e2_vid = e1_vid;
    if (rst) begin
      busy = N;
      e1_sel = '0; e1_x = '0; e1_y = '0; e1_rgb = '0; e1_hs = 1'b0; e1_vs = 1'b0; e1_vid = 1'b0;
      e2_rgb = '0; e2_hs = 1'b0; e2_vs = 1'b0; e2_vid = 1'b0;
      e_ready = 1'b0;
    end else begin
      h = int'(hc);
      v = int'(vc);
      lit = 1'b0;
      e1_sel = 8'd32; e1_x = '0; e1_y = '0;
      if (h >= OX && h < OX + N * CW && v >= OY && v < OY + CW) begin
        rx = h - OX;
        cl = rx / CW;
        dx = (rx / DOT) % 8;
        dy = ((v - OY) / DOT) % 8;
        e1_sel = mbuf[4'(cl)];
        e1_x = 3'(dx);
        e1_y = 3'(dy);
        lit = dx < 5 && rom(mbuf[4'(cl)], dx, dy);
      end
      e1_rgb = video_in && lit ? 12'hFFF : 12'h000;
      e1_hs = hsync_in; e1_vs = vsync_in; e1_vid = video_in;
      if (busy > 0) begin
        mbuf[4'(N - busy)] = 8'd32;
        busy--;
      end else begin
        if (wr_valid && int'(wr_addr) < N) mbuf[wr_addr] = wr_char;
        if (clr) busy = N;
      end
      e_ready = busy == 0;
    end
  end

  // every-cycle comparison of all outputs, plus a record of what each hc produced
  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("rgb_out", 32'(rgb_out), 32'(e2_rgb));
      chk("char_select", 32'(char_select), 32'(e1_sel));
      chk("char_x", 32'(char_x), 32'(e1_x));
      chk("char_y", 32'(char_y), 32'(e1_y));
      chk("hsync_out", 32'(hsync_out), 32'(e2_hs));
      chk("vsync_out", 32'(vsync_out), 32'(e2_vs));
      chk("video_out", 32'(video_out), 32'(e2_vid));
      chk("wr_ready", 32'(wr_ready), 32'(e_ready));
      sel_seen[hc_d1] = char_select;
      rgb_seen[hc_d2] = rgb_out;
      if (rgb_out != 12'h000) lit_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) begin
      hc = 11'(h);
      vc = 11'(v);
      video_in = 1'b1;
      hsync_in = 1'($urandom);
      vsync_in = 1'($urandom);
      tick();
    end
    hc = '0; vc = '0; video_in = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic wr(input int a, input int c);
    wr_valid = 1'b1;
    wr_addr = 4'(a);
    wr_char = 8'(c);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic count_low(input bit inject, output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (wr_ready) break;
      n++;
      if (inject && n == 4) begin
        wr_valid = 1'b1;
        wr_addr = 4'd3;
        wr_char = 8'd65;
      end
      if (n == 5) wr_valid = 1'b0;
    end
  endtask

  initial begin
    int n, base;
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("reset_rgb", 32'(rgb_out), 32'h0);
    chk("reset_select", 32'(char_select), 32'h0);
    chk("reset_ready", 32'(wr_ready), 32'h0);
    chk("reset_hsync", 32'(hsync_out), 32'h0);
    tick();
    rst = 1'b0;
    count_low(1'b0, n);
    chk("ready_low_after_reset", 32'(n), 32'd16);

    base = lit_cnt;
    sweep(64, 64, 575); sweep(80, 64, 575); sweep(95, 64, 575);
    chk("blank_after_reset", 32'(lit_cnt - base), 32'd0);

    wr(0, 97); wr(1, 122);
    base = lit_cnt;
    sweep(72, 64, 127);
    chk("a_select_64", 32'(sel_seen[64]), 32'd97);
    chk("a_select_95", 32'(sel_seen[95]), 32'd97);
    chk("z_select_96", 32'(sel_seen[96]), 32'd122);
    chk("a_rgb_67", 32'(rgb_seen[67]), 32'h000);
    chk("a_rgb_68", 32'(rgb_seen[68]), 32'hFFF);
    chk("a_rgb_79", 32'(rgb_seen[79]), 32'hFFF);
    chk("a_rgb_80", 32'(rgb_seen[80]), 32'h000);
    chk("a_rgb_95", 32'(rgb_seen[95]), 32'h000);
    chk("z_rgb_96", 32'(rgb_seen[96]), 32'hFFF);
    chk("z_rgb_115", 32'(rgb_seen[115]), 32'hFFF);
    chk("z_rgb_116", 32'(rgb_seen[116]), 32'h000);
    chk("z_rgb_127", 32'(rgb_seen[127]), 32'h000);
    chk("az_lit_pixels", 32'(lit_cnt - base), 32'd32);

    wr(15, 65);
    sweep(95, 60, 580);
    chk("edge_rgb_63", 32'(rgb_seen[63]), 32'h000);
    chk("edge_sel_63", 32'(sel_seen[63]), 32'd32);
    chk("last_cell_rgb_560", 32'(rgb_seen[560]), 32'hFFF);
    chk("last_cell_sel_575", 32'(sel_seen[575]), 32'd65);
    chk("edge_rgb_576", 32'(rgb_seen[576]), 32'h000);
    chk("edge_sel_576", 32'(sel_seen[576]), 32'd32);
    sweep(96, 540, 580);
    chk("below_rgb_560", 32'(rgb_seen[560]), 32'h000);
    chk("below_sel_560", 32'(sel_seen[560]), 32'd32);

    hc = 11'd70; vc = 11'd72; video_in = 1'b0;
    tick();
    hc = '0; vc = '0;
    tick(); tick(); tick();
    chk("blank_video_rgb", 32'(rgb_seen[70]), 32'h000);
    chk("blank_video_sel", 32'(sel_seen[70]), 32'd97);

    hsync_in = 1'b0; vsync_in = 1'b0;
    tick(); tick();
    hsync_in = 1'b1;
    tick();
    hsync_in = 1'b0;
    @(negedge clk);
    chk("hsync_delay_1", 32'(hsync_out), 32'd0);
    tick();
    @(negedge clk);
    chk("hsync_delay_2", 32'(hsync_out), 32'd1);
    tick();
    @(negedge clk);
    chk("hsync_delay_3", 32'(hsync_out), 32'd0);
    tick();

    for (int i = 0; i < N; i++) wr(i, 56);
    base = lit_cnt;
    sweep(72, 64, 575);
    chk("eights_lit_pixels", 32'(lit_cnt - base), 32'd320);
    clr = 1'b1;
    wr_valid = 1'b1; wr_addr = 4'd2; wr_char = 8'd56;
    tick();
    clr = 1'b0; wr_valid = 1'b0;
    count_low(1'b1, n);
    chk("ready_low_during_clear", 32'(n), 32'd16);
    tick();
    base = lit_cnt;
    sweep(72, 64, 575);
    chk("cleared_lit_pixels", 32'(lit_cnt - base), 32'd0);
    chk("cleared_sel_entry3", 32'(sel_seen[160]), 32'd32);
    chk("cleared_sel_entry0", 32'(sel_seen[64]), 32'd32);

    wr(5, 65);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_low(1'b0, n);
    chk("ready_low_after_midclear_reset", 32'(n), 32'd16);
    tick();
    base = lit_cnt;
    sweep(72, 224, 255);
    chk("entry5_cleared", 32'(lit_cnt - base), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
